// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop synchronizers, optional glitch filter, one-cycle up/down pulses.
// Define QUAD_GLITCH_FILTER_EN to insert a FILTER_CYCLES stability filter on each channel.
module quad_decoder #(
   parameter int FILTER_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic a_in,
   input  logic b_in,
   input  logic enable,
   input  logic err_clr,
   output logic up,
   output logic down,
   output logic dir,
   output logic err
);

   if (FILTER_CYCLES < 2 || FILTER_CYCLES > 15) begin : g_bad_filter_cycles
      $error("quad_decoder: FILTER_CYCLES must be in 2..15");
   end

   logic a_meta, a_sync;
   logic b_meta, b_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_meta <= 1'b0;
         a_sync <= 1'b0;
         b_meta <= 1'b0;
         b_sync <= 1'b0;
      end else begin
         a_meta <= a_in;
         a_sync <= a_meta;
         b_meta <= b_in;
         b_sync <= b_meta;
      end
   end

   logic [1:0] cur;

`ifdef QUAD_GLITCH_FILTER_EN
   localparam int CW = 4;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

   logic [1:0]    acc;
   logic [CW-1:0] a_cnt, b_cnt;

   // A level is accepted after FILTER_CYCLES consecutive samples differing from acc;
   // falling back to the accepted level restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc   <= 2'b00;
         a_cnt <= '0;
         b_cnt <= '0;
      end else begin
         if (a_sync == acc[1]) begin
            a_cnt <= '0;
         end else if (a_cnt == CNT_LAST) begin
            acc[1] <= a_sync;
            a_cnt  <= '0;
         end else begin
            a_cnt <= a_cnt + 1'b1;
         end

         if (b_sync == acc[0]) begin
            b_cnt <= '0;
         end else if (b_cnt == CNT_LAST) begin
            acc[0] <= b_sync;
            b_cnt  <= '0;
         end else begin
            b_cnt <= b_cnt + 1'b1;
         end
      end
   end

   assign cur = acc;
`else
   assign cur = {a_sync, b_sync};
`endif

   logic [1:0] prev;
   logic       init_done;
   logic [1:0] chg;
   logic       single, step_fwd, step_rev, step_bad;

   // Gray order 00->01->11->10: moving forward flips B when A==B and flips A when A!=B.
   assign chg      = cur ^ prev;
   assign single   = chg[1] ^ chg[0];
   assign step_fwd = single & (chg[0] ^ prev[1] ^ prev[0]);
   assign step_rev = single & ~(chg[0] ^ prev[1] ^ prev[0]);
   assign step_bad = chg[1] & chg[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         prev      <= 2'b00;
         init_done <= 1'b0;
         up        <= 1'b0;
         down      <= 1'b0;
         dir       <= 1'b0;
         err       <= 1'b0;
      end else begin
         up        <= 1'b0;
         down      <= 1'b0;
         prev      <= cur;
         init_done <= 1'b1;
         if (init_done && step_fwd) begin
            dir <= 1'b1;
            up  <= enable;
         end
         if (init_done && step_rev) begin
            dir  <= 1'b0;
            down <= enable;
         end
         // A new illegal step wins over a simultaneous clear.
         if (init_done && step_bad) begin
            err <= 1'b1;
         end else if (err_clr) begin
            err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: table-driven step sequences, hand-written corner cases and
// randomized stimulus against a position-arithmetic reference model.
module tb_quad_decoder;

`ifdef QUAD_GLITCH_FILTER_EN
   localparam int LAT = 3 + 4;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic a_in = 1'b0;
   logic b_in = 1'b0;
   logic enable = 1'b1;
   logic err_clr = 1'b0;
   logic up, down, dir, err;

   quad_decoder #(.FILTER_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .enable(enable),
      .err_clr(err_clr), .up(up), .down(down), .dir(dir), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int up_cnt = 0;
   int down_cnt = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: positions on the quadrature circle, step = position delta mod 4.
   logic [1:0] m_pipe[$];
   logic [1:0] m_prev;
   logic       m_init, m_up, m_down, m_dir, m_err;
   logic       model_on = 1'b0;

   function automatic int pos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_tick();
      logic [1:0] cur;
      int d;
      logic illegal;
      if (reset) begin
         m_pipe = '{2'b00, 2'b00};
         m_prev = 2'b00;
         m_init = 1'b0;
         m_up = 1'b0; m_down = 1'b0; m_dir = 1'b0; m_err = 1'b0;
      end else begin
         cur = m_pipe.pop_front();
         m_pipe.push_back({a_in, b_in});
         m_up = 1'b0;
         m_down = 1'b0;
         illegal = 1'b0;
         if (!m_init) begin
            m_init = 1'b1;
         end else begin
            d = (pos(cur) - pos(m_prev) + 4) % 4;
            if (d == 1) begin m_dir = 1'b1; m_up = enable; end
            else if (d == 3) begin m_dir = 1'b0; m_down = enable; end
            else if (d == 2) illegal = 1'b1;
         end
         m_prev = cur;
         if (illegal) m_err = 1'b1;
         else if (err_clr) m_err = 1'b0;
      end
   endtask

   task automatic step_cycle();
      @(posedge clk);
`ifndef QUAD_GLITCH_FILTER_EN
      model_tick();
`endif
      @(negedge clk);
      if (up === 1'b1) up_cnt++;
      if (down === 1'b1) down_cnt++;
      check("up_down_exclusive", {31'd0, up & down}, 32'd0);
`ifndef QUAD_GLITCH_FILTER_EN
      if (model_on) begin
         check("model_up", {31'd0, up}, {31'd0, m_up});
         check("model_down", {31'd0, down}, {31'd0, m_down});
         check("model_dir", {31'd0, dir}, {31'd0, m_dir});
         check("model_err", {31'd0, err}, {31'd0, m_err});
      end
`endif
   endtask

   typedef struct {
      logic       rst;
      logic [1:0] ab;
      logic       en;
      logic       clr;
      int         hold;
      int         exp_up;
      int         exp_down;
      logic       exp_dir;
      logic       exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic rst, input logic [1:0] ab, input logic en, input logic clr,
                               input int hold, input int eu, input int ed, input logic edir, input logic eerr);
      vec_t v;
      v = '{rst, ab, en, clr, hold, eu, ed, edir, eerr};
      vecs.push_back(v);
   endfunction

   initial begin
      int lat;
      // forward sequence
      add(1, 2'b00, 1, 0, 2, 0, 0, 0, 0);
      add(0, 2'b00, 1, 0, 8, 0, 0, 0, 0);
      add(0, 2'b01, 1, 0, 8, 1, 0, 1, 0);
      add(0, 2'b11, 1, 0, 8, 1, 0, 1, 0);
      add(0, 2'b10, 1, 0, 8, 1, 0, 1, 0);
      add(0, 2'b00, 1, 0, 8, 1, 0, 1, 0);
      // reverse sequence then one forward step
      add(0, 2'b10, 1, 0, 8, 0, 1, 0, 0);
      add(0, 2'b11, 1, 0, 8, 0, 1, 0, 0);
      add(0, 2'b01, 1, 0, 8, 0, 1, 0, 0);
      add(0, 2'b00, 1, 0, 8, 0, 1, 0, 0);
      add(0, 2'b01, 1, 0, 8, 1, 0, 1, 0);
      // illegal 01->10, then clear
      add(0, 2'b10, 1, 0, 8, 0, 0, 1, 1);
      add(0, 2'b10, 1, 1, 1, 0, 0, 1, 0);
      add(0, 2'b10, 1, 0, 7, 0, 0, 1, 0);
      // enable low still tracks position and direction
      add(1, 2'b00, 1, 0, 2, 0, 0, 0, 0);
      add(0, 2'b00, 1, 0, 8, 0, 0, 0, 0);
      add(0, 2'b10, 1, 0, 8, 0, 1, 0, 0);
      add(0, 2'b11, 1, 0, 8, 0, 1, 0, 0);
      add(0, 2'b01, 1, 0, 8, 0, 1, 0, 0);
      add(0, 2'b00, 1, 0, 8, 0, 1, 0, 0);
      add(0, 2'b01, 0, 0, 8, 0, 0, 1, 0);
      add(0, 2'b11, 0, 0, 8, 0, 0, 1, 0);
      add(0, 2'b10, 1, 0, 8, 1, 0, 1, 0);
      // reset midway through a forward step 10->00
      add(0, 2'b00, 1, 0, 1, 0, 0, 1, 0);
      add(1, 2'b00, 1, 0, 1, 0, 0, 0, 0);
      add(0, 2'b00, 1, 0, 8, 0, 0, 0, 0);
      add(0, 2'b01, 1, 0, 8, 1, 0, 1, 0);

      model_on = 1'b1;
      foreach (vecs[i]) begin
         reset = vecs[i].rst;
         {a_in, b_in} = vecs[i].ab;
         enable = vecs[i].en;
         err_clr = vecs[i].clr;
         up_cnt = 0;
         down_cnt = 0;
         repeat (vecs[i].hold) step_cycle();
         check($sformatf("vec%0d_up_count", i), up_cnt, vecs[i].exp_up);
         check($sformatf("vec%0d_down_count", i), down_cnt, vecs[i].exp_down);
         check($sformatf("vec%0d_dir", i), {31'd0, dir}, {31'd0, vecs[i].exp_dir});
         check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      end
      reset = 1'b0;
      err_clr = 1'b0;

      // illegal 00->11, clear, then illegal 11->00 with err_clr on the decode cycle
      {a_in, b_in} = 2'b00;
      repeat (10) step_cycle();
      up_cnt = 0;
      down_cnt = 0;
      {a_in, b_in} = 2'b11;
      repeat (10) step_cycle();
      check("illegal_err_set", {31'd0, err}, 32'd1);
      check("illegal_no_pulse", up_cnt + down_cnt, 0);
      err_clr = 1'b1;
      step_cycle();
      err_clr = 1'b0;
      check("err_cleared", {31'd0, err}, 32'd0);
      {a_in, b_in} = 2'b00;
      repeat (LAT - 1) step_cycle();
      check("err_before_decode", {31'd0, err}, 32'd0);
      err_clr = 1'b1;
      step_cycle();
      err_clr = 1'b0;
      check("illegal_beats_clear", {31'd0, err}, 32'd1);
      repeat (8) step_cycle();
      err_clr = 1'b1;
      step_cycle();
      err_clr = 1'b0;

      // edge-to-pulse latency on 00->01
      {a_in, b_in} = 2'b01;
      lat = 0;
      up_cnt = 0;
      while (up_cnt == 0 && lat < 20) begin
         step_cycle();
         lat++;
      end
      check("latency_00_01", lat, LAT);
      repeat (10) step_cycle();

`ifdef QUAD_GLITCH_FILTER_EN
      // a 2-cycle glitch on A must be rejected
      {a_in, b_in} = 2'b00;
      repeat (12) step_cycle();
      up_cnt = 0;
      down_cnt = 0;
      {a_in, b_in} = 2'b10;
      repeat (2) step_cycle();
      {a_in, b_in} = 2'b00;
      repeat (12) step_cycle();
      check("glitch_no_pulse", up_cnt + down_cnt, 0);
`else
      // randomized stimulus against the model
      for (int k = 0; k < 400; k++) begin
         reset = ($urandom_range(0, 40) == 0);
         {a_in, b_in} = 2'($urandom_range(0, 3));
         enable = ($urandom_range(0, 5) != 0);
         err_clr = ($urandom_range(0, 7) == 0);
         repeat ($urandom_range(1, 4)) step_cycle();
      end
      reset = 1'b0;
      err_clr = 1'b0;
      repeat (5) step_cycle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FILTER_CYCLES, default 4, number of consecutive stable samples a synchronized input needs before it is accepted. Used only when QUAD_GLITCH_FILTER_EN is defined; legal range 2..15.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 a_in  input  1  quadrature channel A; asynchronous to clk.
REQ-005 b_in  input  1  quadrature channel B; asynchronous to clk.
REQ-006 enable  input  1  1 = step pulses emitted; 0 = pulses suppressed.
REQ-007 err_clr  input  1  clears the sticky err flag.
REQ-008 up  output  1  one-cycle pulse per forward step; drives a counter's up input.
REQ-009 down  output  1  one-cycle pulse per reverse step; drives a counter's down input.
REQ-010 dir  output  1  direction of the last valid step; 1 = forward, 0 = reverse.
REQ-011 err  output  1  sticky flag for an illegal transition (both channels changed in one sample).

Function
REQ-012 a_in and b_in each SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 The decoder SHALL register the previous accepted state prev[1:0] = {A,B} and compare it with the current accepted state cur each cycle.
REQ-014 Forward steps: 00->01, 01->11, 11->10, 10->00. Each forward step SHALL produce up=1 for exactly one cycle and set dir=1.
REQ-015 Reverse steps: 00->10, 10->11, 11->01, 01->00. Each reverse step SHALL produce down=1 for exactly one cycle and set dir=0.
REQ-016 If cur equals prev, the decoder SHALL produce no pulse and leave dir unchanged.
REQ-017 Illegal step (both bits differ: 00<->11, 01<->10): the decoder SHALL produce no pulse, leave dir unchanged, set err=1, and update prev to cur.
REQ-018 up and down SHALL never be 1 in the same cycle.
REQ-019 Latency without the filter: an input edge SHALL produce its pulse exactly 3 clk cycles later (2 synchronizer cycles + 1 decode register).
REQ-020 With enable=0, prev SHALL still track cur, up and down SHALL stay 0, and dir and err SHALL still update.
REQ-021 err_clr=1 SHALL clear err on the next edge. If an illegal step occurs in the same cycle as err_clr, err SHALL be 1.
REQ-022 Input toggling faster than one edge per clk cycle is outside the legal range; the only required response is err.

Reset
REQ-023 While reset=1 at posedge clk: synchronizer flops, prev, up, down, dir and err SHALL all be 0, and the init flag SHALL be cleared.
REQ-024 On the first cycle after reset is released, the accepted state SHALL load into prev with no pulse and no err; decoding starts on the following cycle.
REQ-025 Reset asserted mid-sequence SHALL take priority over any pending pulse; no pulse is emitted in the reset cycle.

Configuration
REQ-026 Macro QUAD_GLITCH_FILTER_EN defined: each synchronized channel SHALL feed a stability counter. The accepted value SHALL update only after the new level has been sampled for FILTER_CYCLES consecutive cycles, and any change restarts the count. Latency becomes 3 + FILTER_CYCLES cycles.
REQ-027 Macro QUAD_GLITCH_FILTER_EN undefined: the accepted value SHALL equal the synchronized value, no counter logic SHALL exist, and latency is 3 cycles.

Verification
REQ-028 Forward: reset, then {A,B} = 00,01,11,10,00, each step held 8 cycles -> exactly 4 up pulses, 0 down pulses, dir=1, err=0.
REQ-029 Reverse: from 00, apply 10,11,01,00 -> 4 down pulses, dir=0. Then one forward step 00->01 -> 1 up pulse, dir=1.
REQ-030 Illegal: 00->11 in one step -> err=1, no pulse. Pulse err_clr for one cycle -> err=0 on the next cycle. Repeat with err_clr high in the step cycle -> err=1.
REQ-031 Filter (macro on, FILTER_CYCLES=4): A pulse lasting 2 cycles -> no pulse. A held 00->01 step -> up exactly 7 cycles after the edge.
REQ-032 enable=0 during 00->01->11 -> no pulses and dir=1. Set enable=1, then step 11->10 -> 1 up pulse.
REQ-033 Assert reset for 1 cycle midway through a forward step -> all outputs 0, no pulse for the step, next legal step pulses normally.
